// File: rtl/viterbi_pkg.sv
// Shared constants, encodings and the trellis back-step used by the Viterbi
// traceback controller and its output buffer.
package viterbi_pkg;

    localparam int N_STATES = 64;
    localparam int STATE_W  = 6;
    localparam int PERIOD   = 32;
    localparam int PERIOD_W = 5;

    localparam logic [PERIOD_W-1:0] PH_LAST       = PERIOD_W'(PERIOD - 1);
    localparam logic [2:0]          PN_FULL       = 3'd4;
    localparam logic [2:0]          FLUSH_PERIODS = 3'd4;

    typedef enum logic [1:0] {
        BANK_A = 2'd0,
        BANK_B = 2'd1,
        BANK_C = 2'd2,
        BANK_D = 2'd3
    } bank_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } tb_state_e;

    // s[0] is the newest input, so stepping back shifts the survivor bit in at the top.
    function automatic logic [STATE_W-1:0] prev_state(input logic [N_STATES-1:0] word,
                                                      input logic [STATE_W-1:0]  s);
        return {word[s], s[STATE_W-1:1]};
    endfunction

endpackage

// File: rtl/viterbi_traceback_ctrl_reverse_buf.sv
// Ping-pong bit buffer: one half fills in reverse address order while the
// other half is read out forward; the halves trade places on swap_i.
module tb_reverse_buf
    import viterbi_pkg::*;
(
    input  logic                clk,
    input  logic                RSTn,
    input  logic                wrEn_i,
    input  logic [PERIOD_W-1:0] wrIdx_i,
    input  logic                wrBit_i,
    input  logic [PERIOD_W-1:0] rdIdx_i,
    input  logic                swap_i,
    output logic                rdBit_o
);

    logic [PERIOD-1:0] bufA_q;
    logic [PERIOD-1:0] bufB_q;
    logic              writeSel_q;

    // A write landing on the swap edge still belongs to the half being closed.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            bufA_q     <= '0;
            bufB_q     <= '0;
            writeSel_q <= 1'b0;
        end else begin
            if (wrEn_i && !writeSel_q) begin
                bufA_q[wrIdx_i] <= wrBit_i;
            end
            if (wrEn_i && writeSel_q) begin
                bufB_q[wrIdx_i] <= wrBit_i;
            end
            if (swap_i) begin
                writeSel_q <= !writeSel_q;
            end
        end
    end

    assign rdBit_o = writeSel_q ? bufA_q[rdIdx_i] : bufB_q[rdIdx_i];

endmodule

// File: rtl/viterbi_traceback_ctrl.sv
// Traceback/decode sequencer for the four-bank survivor memory: runs the
// memory counters, walks the trellis backwards and emits bits in forward order.
module viterbi_traceback_ctrl
    import viterbi_pkg::*;
#(
    parameter int                 RD_LAT      = 2,
    parameter logic [STATE_W-1:0] START_STATE = 6'd0
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                d_in_valid,
    input  logic [1:0]          mem_bank,
    input  logic [N_STATES-1:0] d_o_mem_A,
    input  logic [N_STATES-1:0] d_o_mem_B,
    input  logic [N_STATES-1:0] d_o_mem_C,
    input  logic [N_STATES-1:0] d_o_mem_D,
    output logic                process_en,
    output logic                dec_bit,
    output logic                dec_valid,
    output logic                busy
);

    tb_state_e state_q;
    tb_state_e state_d;

    logic [PERIOD_W-1:0] ph_q;
    logic [2:0]          pn_q;
    logic [2:0]          flushLeft_q;
    logic                sawGap_q;
    logic                sawAny_q;

    logic periodEnd;
    logic sawGapNow;
    logic sawAnyNow;

    logic [RD_LAT-1:0]               actDly_q;
    logic [RD_LAT-1:0][PERIOD_W-1:0] phDly_q;
    logic [RD_LAT-1:0][1:0]          bankDly_q;
    logic [RD_LAT-1:0]               fullDly_q;

    logic                actD;
    logic [PERIOD_W-1:0] phD;
    logic [1:0]          bankD;
    logic                fullD;

    bank_e               traceBank;
    bank_e               decodeBank;
    logic [N_STATES-1:0] traceWord;
    logic [N_STATES-1:0] decodeWord;

    logic [STATE_W-1:0] ts_q;
    logic [STATE_W-1:0] ds_q;
    logic [STATE_W-1:0] dsStart_q;
    logic [STATE_W-1:0] traceCur;
    logic [STATE_W-1:0] traceNext;
    logic [STATE_W-1:0] decodeCur;
    logic [STATE_W-1:0] decodeNext;

    logic rdBit;

    assign periodEnd = (ph_q == PH_LAST);
    assign sawGapNow = sawGap_q | ~d_in_valid;
    assign sawAnyNow = sawAny_q | d_in_valid;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (periodEnd && sawGapNow) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (periodEnd && flushLeft_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RSTn gates process_en so a held-low reset never lets the memory advance.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        process_en = RSTn & ((state_q != ST_IDLE) | d_in_valid);
    end

    // A period with no input at all already counts as the first flush period.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            ph_q        <= '0;
            pn_q        <= '0;
            sawGap_q    <= 1'b0;
            sawAny_q    <= 1'b0;
            flushLeft_q <= '0;
        end else begin
            if (process_en) begin
                ph_q <= ph_q + PERIOD_W'(1);
                if (periodEnd && pn_q != PN_FULL) begin
                    pn_q <= pn_q + 3'd1;
                end
                sawGap_q <= periodEnd ? 1'b0 : sawGapNow;
                sawAny_q <= periodEnd ? 1'b0 : sawAnyNow;
            end else begin
                ph_q     <= '0;
                pn_q     <= '0;
                sawGap_q <= 1'b0;
                sawAny_q <= 1'b0;
            end
            if (state_q == ST_RUN && state_d == ST_FLUSH) begin
                flushLeft_q <= sawAnyNow ? FLUSH_PERIODS : FLUSH_PERIODS - 3'd1;
            end else if (state_q == ST_FLUSH && periodEnd) begin
                flushLeft_q <= flushLeft_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            actDly_q  <= '0;
            phDly_q   <= '0;
            bankDly_q <= '0;
            fullDly_q <= '0;
        end else begin
            actDly_q[0]  <= process_en;
            phDly_q[0]   <= ph_q;
            bankDly_q[0] <= mem_bank;
            fullDly_q[0] <= (pn_q == PN_FULL);
            for (int i = 1; i < RD_LAT; i++) begin
                actDly_q[i]  <= actDly_q[i-1];
                phDly_q[i]   <= phDly_q[i-1];
                bankDly_q[i] <= bankDly_q[i-1];
                fullDly_q[i] <= fullDly_q[i-1];
            end
        end
    end

    assign actD  = actDly_q[RD_LAT-1];
    assign phD   = phDly_q[RD_LAT-1];
    assign bankD = bankDly_q[RD_LAT-1];
    assign fullD = fullDly_q[RD_LAT-1];

    // Traceback reads the bank finished last period, decode the one three back.
    assign traceBank  = bank_e'(bankD - 2'd1);
    assign decodeBank = bank_e'(bankD + 2'd1);

    always_comb begin
        traceWord  = '0;
        decodeWord = '0;
        case (traceBank)
            BANK_A: traceWord = d_o_mem_A;
            BANK_B: traceWord = d_o_mem_B;
            BANK_C: traceWord = d_o_mem_C;
            BANK_D: traceWord = d_o_mem_D;
            default: traceWord = '0;
        endcase
        case (decodeBank)
            BANK_A: decodeWord = d_o_mem_A;
            BANK_B: decodeWord = d_o_mem_B;
            BANK_C: decodeWord = d_o_mem_C;
            BANK_D: decodeWord = d_o_mem_D;
            default: decodeWord = '0;
        endcase
    end

    always_comb begin
        traceCur   = (phD == '0) ? START_STATE : ts_q;
        decodeCur  = (phD == '0) ? dsStart_q : ds_q;
        traceNext  = prev_state(traceWord, traceCur);
        decodeNext = prev_state(decodeWord, decodeCur);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            ts_q      <= '0;
            ds_q      <= '0;
            dsStart_q <= '0;
        end else if (actD) begin
            ts_q <= traceNext;
            ds_q <= decodeNext;
            if (phD == PH_LAST) begin
                dsStart_q <= traceNext;
            end
        end
    end

    tb_reverse_buf u_reverse_buf (
        .clk     (clk),
        .RSTn    (RSTn),
        .wrEn_i  (actD),
        .wrIdx_i (PH_LAST - phD),
        .wrBit_i (decodeCur[0]),
        .rdIdx_i (phD),
        .swap_i  (actD && phD == PH_LAST),
        .rdBit_o (rdBit)
    );

    assign dec_valid = actD & fullD;
    assign dec_bit   = dec_valid & rdBit;

endmodule
